// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming KxK non-overlapping pooling engine with a per-output-column line buffer.
// Define POOL2D_AVG_EN to make average pooling available via pool_mode; otherwise the block is max-only.
module pool2d_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int POOL_K     = 2,
  parameter int IMG_W_MAX  = 64,
  parameter int IMG_H_MAX  = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(IMG_W_MAX+1)-1:0]   img_w,
  input  logic [$clog2(IMG_H_MAX+1)-1:0]   img_h,
  input  logic                             pool_mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]   out_data,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             cfg_err
);
  localparam int WW   = $clog2(IMG_W_MAX+1);
  localparam int HW   = $clog2(IMG_H_MAX+1);
  localparam int LOGK = $clog2(POOL_K);
  localparam int NOC  = IMG_W_MAX / POOL_K;
  localparam int OCW  = (NOC > 1) ? $clog2(NOC) : 1;
`ifdef POOL2D_AVG_EN
  localparam int ACC_W = DATA_WIDTH + 2*LOGK;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif
  localparam int DW_ALL = CHANNELS*DATA_WIDTH;
  localparam int AW_ALL = CHANNELS*ACC_W;
  localparam logic [WW-1:0] W_MASK = ~WW'(POOL_K-1);
  localparam logic [HW-1:0] H_MASK = ~HW'(POOL_K-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       col_q, col_d, w_q, w_d;
  logic [HW-1:0]       row_q, row_d, h_q, h_d;
  logic                out_valid_q, out_valid_d;
  logic [DW_ALL-1:0]   out_data_q, out_data_d;
  logic                frame_done_q, frame_done_d;
  logic                cfg_err_q, cfg_err_d;
`ifdef POOL2D_AVG_EN
  logic                mode_q, mode_d;
`else
  logic                unused_pool_mode;
  assign unused_pool_mode = pool_mode;
`endif

  logic [AW_ALL-1:0]   lbuf_q [NOC];
  logic [AW_ALL-1:0]   acc_new;
  logic [DW_ALL-1:0]   result;
  logic                lbuf_we;
  logic                hs, cfg_ok, in_win, win_first, win_last, last_col, last_pix;
  logic [OCW-1:0]      oc;

  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign hs         = in_valid && in_ready;
  assign oc         = OCW'(col_q >> LOGK);
  assign cfg_ok     = (img_w >= WW'(POOL_K)) && (img_w <= WW'(IMG_W_MAX)) &&
                      (img_h >= HW'(POOL_K)) && (img_h <= HW'(IMG_H_MAX));
  // Pixels beyond the last whole window in either direction are dropped.
  assign in_win     = (col_q < (w_q & W_MASK)) && (row_q < (h_q & H_MASK));
  assign win_first  = (col_q[LOGK-1:0] == '0) && (row_q[LOGK-1:0] == '0);
  assign win_last   = (&col_q[LOGK-1:0]) && (&row_q[LOGK-1:0]);
  assign last_col   = (col_q == w_q - 1'b1);
  assign last_pix   = last_col && (row_q == h_q - 1'b1);

  assign busy       = (state_q == RUN);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

  always_comb begin
    acc_new = '0;
    result  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      logic signed [ACC_W-1:0] px, prev, acc;
`ifdef POOL2D_AVG_EN
      logic signed [ACC_W-1:0] shifted;
`endif
      px   = ACC_W'(signed'(in_data[c*DATA_WIDTH +: DATA_WIDTH]));
      prev = lbuf_q[oc][c*ACC_W +: ACC_W];
      acc  = px;
      if (win_first)
        acc = px;
`ifdef POOL2D_AVG_EN
      else if (mode_q)
        acc = prev + px;
`endif
      else
        acc = (px > prev) ? px : prev;
      acc_new[c*ACC_W +: ACC_W] = acc;
`ifdef POOL2D_AVG_EN
      // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
      shifted = mode_q ? (acc >>> (2*LOGK)) : acc;
      result[c*DATA_WIDTH +: DATA_WIDTH] = shifted[DATA_WIDTH-1:0];
`else
      result[c*DATA_WIDTH +: DATA_WIDTH] = acc[DATA_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    h_d          = h_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    lbuf_we      = 1'b0;
`ifdef POOL2D_AVG_EN
    mode_d       = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = RUN;
            w_d     = img_w;
            h_d     = img_h;
            col_d   = '0;
            row_d   = '0;
`ifdef POOL2D_AVG_EN
            mode_d  = pool_mode;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (in_win) begin
            if (win_last) begin
              out_valid_d = 1'b1;
              out_data_d  = result;
            end else begin
              lbuf_we = 1'b1;
            end
          end
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef POOL2D_AVG_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef POOL2D_AVG_EN
      mode_q       <= mode_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[oc] <= acc_new;
  end

endmodule
